mem_ctrl: RTL

Byte-serial memory controller between the CPU's two memory clients and the 8-bit RAM/IO bus. It accepts 4-byte instruction-fetch reads and 1/2/4-byte LSU loads and stores, and arbitrates between them with LSU priority. It sequences byte accesses with pipelined addressing, assembles and splits little-endian words, and stalls IO writes while the IO buffer is full. Sits directly downstream of the LSU (its `*_to_mem` / `*_from_mem` ports) and the instruction fetch unit.

---
 rtl/mem_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial controller between instruction fetch / LSU and the 8-bit RAM/IO bus.
// LSU has priority; words are split and assembled little-endian over n byte cycles.
module mem_ctrl #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_en,
    input  logic [31:0] if_addr,
    output logic        if_ok,
    output logic [31:0] if_data,
    input  logic        lsu_en,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_data,
    input  logic        lsu_rw,
    input  logic [2:0]  lsu_size,
    output logic        lsu_ok,
    output logic [31:0] lsu_result,
    input  logic        rollback_flag_from_rob
);

    localparam logic READ_FLAG = 1'b0;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  n_q, n_d;
    logic        is_if_q, is_if_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_ok_q, if_ok_d;
    logic        lsu_ok_q, lsu_ok_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] lsu_res_q, lsu_res_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic        pend_rw_q, pend_rw_d;
    logic [2:0]  pend_size_q, pend_size_d;

    logic [31:0] cur_a;
    logic [4:0]  sh;

    function automatic logic [2:0] byte_count(input logic [2:0] sz);
        case (sz)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic io_stall(input logic [31:0] a, input logic full);
        return (a[17:16] == IO_SEL) && full;
    endfunction

    assign cur_a = addr_q + {29'b0, cnt_q};
    assign sh    = {cnt_q[1:0], 3'b000};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        is_if_d     = is_if_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = mem_wr_q;
        if_ok_d     = 1'b0;
        lsu_ok_d    = 1'b0;
        if_data_d   = if_data_q;
        lsu_res_d   = lsu_res_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        pend_rw_d   = pend_rw_q;
        pend_size_d = pend_size_q;

        // A request arriving this edge is visible to IDLE at once.
        if (lsu_en) begin
            pend_v_d    = 1'b1;
            pend_addr_d = lsu_addr;
            pend_data_d = lsu_data;
            pend_rw_d   = lsu_rw;
            pend_size_d = lsu_size;
        end
        if (rollback_flag_from_rob && pend_rw_d == READ_FLAG) begin
            pend_v_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (pend_v_d) begin
                    pend_v_d = 1'b0;
                    is_if_d  = 1'b0;
                    addr_d   = pend_addr_d;
                    n_d      = byte_count(pend_size_d);
                    cnt_d    = 3'd0;
                    mem_a_d  = pend_addr_d;
                    if (pend_rw_d != READ_FLAG) begin
                        state_d = WRITE;
                        data_d  = pend_data_d;
                        if (io_stall(pend_addr_d, io_buffer_full)) begin
                            mem_wr_d = 1'b0;
                        end else begin
                            mem_dout_d = pend_data_d[7:0];
                            mem_wr_d   = 1'b1;
                            cnt_d      = 3'd1;
                        end
                    end else begin
                        state_d  = READ;
                        data_d   = '0;
                        mem_wr_d = 1'b0;
                    end
                end else if (if_en && !rollback_flag_from_rob) begin
                    state_d  = READ;
                    is_if_d  = 1'b1;
                    addr_d   = if_addr;
                    n_d      = 3'd4;
                    cnt_d    = 3'd0;
                    mem_a_d  = if_addr;
                    data_d   = '0;
                    mem_wr_d = 1'b0;
                end
            end
            READ: begin
                if (rollback_flag_from_rob) begin
                    state_d  = IDLE;
                    mem_wr_d = 1'b0;
                end else if (cnt_q == n_q) begin
                    state_d = IDLE;
                    if (is_if_q) begin
                        if_ok_d   = 1'b1;
                        if_data_d = data_q;
                    end else begin
                        lsu_ok_d  = 1'b1;
                        lsu_res_d = data_q;
                    end
                end else begin
                    if (cnt_q + 3'd1 < n_q) begin
                        mem_a_d = cur_a + 32'd1;
                    end
                    data_d[sh +: 8] = mem_din;
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WRITE: begin
                if (cnt_q == n_q) begin
                    state_d  = IDLE;
                    mem_wr_d = 1'b0;
                    lsu_ok_d = 1'b1;
                end else if (io_stall(cur_a, io_buffer_full)) begin
                    mem_wr_d = 1'b0;
                end else begin
                    mem_a_d    = cur_a;
                    mem_dout_d = data_q[sh +: 8];
                    mem_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            is_if_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            if_ok_q     <= 1'b0;
            lsu_ok_q    <= 1'b0;
            if_data_q   <= '0;
            lsu_res_q   <= '0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            pend_rw_q   <= 1'b0;
            pend_size_q <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            is_if_q     <= is_if_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_ok_q     <= if_ok_d;
            lsu_ok_q    <= lsu_ok_d;
            if_data_q   <= if_data_d;
            lsu_res_q   <= lsu_res_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            pend_rw_q   <= pend_rw_d;
            pend_size_q <= pend_size_d;
        end
    end

    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign mem_wr     = mem_wr_q;
    assign if_ok      = if_ok_q;
    assign lsu_ok     = lsu_ok_q;
    assign if_data    = if_data_q;
    assign lsu_result = lsu_res_q;

endmodule
